// File: rtl/systolic_result_collector.sv
// ============================================================================
// systolic_result_collector
//   Captures one result per active array lane, then streams them lowest-first.
// Revision: 1.0
// ============================================================================
`default_nettype none

module systolic_result_collector #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_UNITS  = 16,
    parameter int IDX_W      = $clog2(NUM_UNITS)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [NUM_UNITS-1:0]                 active_units,
    input  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] result_array,
    input  logic [NUM_UNITS-1:0]                 ready_array,
    output logic [DATA_WIDTH-1:0]                out_data,
    output logic [IDX_W-1:0]                     out_idx,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 out_last,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 start_dropped
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_UNITS-1:0]   job_mask_q, job_mask_d;
    logic [NUM_UNITS-1:0]   captured_q, captured_d;
    logic [NUM_UNITS-1:0]   pending_q, pending_d;
    logic                   done_q, done_d;
    logic                   dropped_q, dropped_d;
    logic [DATA_WIDTH-1:0]  result_buf_q [NUM_UNITS];

    logic [NUM_UNITS-1:0]   capture_en;
    logic [NUM_UNITS-1:0]   ptr_onehot;
    logic [IDX_W-1:0]       ptr;
    logic                   last_beat;
    logic                   drain_q;

    assign drain_q    = (state_q == ST_DRAIN);
    // Only the first ready of each job lane is taken, so a held level never overwrites.
    assign capture_en = (state_q == ST_COLLECT) ? (job_mask_q & ready_array & ~captured_q)
                                                : '0;
    assign ptr_onehot = pending_q & (~pending_q + NUM_UNITS'(1));
    assign last_beat  = (pending_q != '0) && ((pending_q & (pending_q - NUM_UNITS'(1))) == '0);

    always_comb begin
        ptr = '0;
        for (int i = NUM_UNITS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                ptr = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        job_mask_d = job_mask_q;
        captured_d = captured_q;
        pending_d  = pending_q;
        done_d     = 1'b0;
        dropped_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (active_units != '0) begin
                        job_mask_d = active_units;
                        captured_d = '0;
                        state_d    = ST_COLLECT;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_COLLECT: begin
                dropped_d  = start;
                captured_d = captured_q | capture_en;
                if ((captured_q | capture_en) == job_mask_q) begin
                    pending_d = job_mask_q;
                    state_d   = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                dropped_d = start;
                if (out_ready) begin
                    pending_d = pending_q & ~ptr_onehot;
                    if (last_beat) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            job_mask_q <= '0;
            captured_q <= '0;
            pending_q  <= '0;
            done_q     <= 1'b0;
            dropped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            job_mask_q <= job_mask_d;
            captured_q <= captured_d;
            pending_q  <= pending_d;
            done_q     <= done_d;
            dropped_q  <= dropped_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (reset) begin
                result_buf_q[i] <= '0;
            end else if (capture_en[i]) begin
                result_buf_q[i] <= result_array[i];
            end
        end
    end

    // Outputs derive only from registers; data/idx are forced to zero outside DRAIN.
    assign out_valid     = drain_q;
    assign out_data      = drain_q ? result_buf_q[ptr] : '0;
    assign out_idx       = drain_q ? ptr : '0;
    assign out_last      = drain_q && last_beat;
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign start_dropped = dropped_q;

endmodule

`default_nettype wire

// File: tb/tb_systolic_result_collector.sv
// ============================================================================
// tb_systolic_result_collector
//   Directed self-checking bench for systolic_result_collector.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_systolic_result_collector;

    localparam int DW = 16;
    localparam int NU = 16;
    localparam int IW = 4;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   start;
    logic [NU-1:0]          active_units;
    logic [NU-1:0][DW-1:0]  result_array;
    logic [NU-1:0]          ready_array;
    logic                   out_ready;
    logic [DW-1:0]          out_data;
    logic [IW-1:0]          out_idx;
    logic                   out_valid;
    logic                   out_last;
    logic                   busy;
    logic                   done;
    logic                   start_dropped;

    int n_cmp = 0;
    int n_err = 0;

    systolic_result_collector #(
        .DATA_WIDTH (DW),
        .NUM_UNITS  (NU),
        .IDX_W      (IW)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .active_units  (active_units),
        .result_array  (result_array),
        .ready_array   (ready_array),
        .out_data      (out_data),
        .out_idx       (out_idx),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .busy          (busy),
        .done          (done),
        .start_dropped (start_dropped)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_beat(input string tag, input int idx, input logic [15:0] data,
                              input logic last);
        check_val({tag, " valid"}, 32'(out_valid), 32'd1);
        check_val({tag, " idx"},   32'(out_idx),   32'(idx));
        check_val({tag, " data"},  32'(out_data),  32'(data));
        check_val({tag, " last"},  32'(out_last),  32'(last));
    endtask

    task automatic check_quiet(input string tag);
        check_val({tag, " valid"},   32'(out_valid),     32'd0);
        check_val({tag, " last"},    32'(out_last),      32'd0);
        check_val({tag, " busy"},    32'(busy),          32'd0);
        check_val({tag, " done"},    32'(done),          32'd0);
        check_val({tag, " dropped"}, 32'(start_dropped), 32'd0);
        check_val({tag, " data"},    32'(out_data),      32'd0);
        check_val({tag, " idx"},     32'(out_idx),       32'd0);
    endtask

    initial begin : stim
        int          t1_idx [4];
        logic [15:0] t1_dat [4];
        int          t3_idx [4];
        logic [15:0] t3_dat [4];
        logic        t3_rdy [6];
        int          pos;

        t1_idx = '{0, 3, 5, 15};
        t1_dat = '{16'hA000, 16'hA303, 16'hA505, 16'hAF0F};
        t3_idx = '{1, 2, 8, 12};
        t3_dat = '{16'h3011, 16'h3022, 16'h3088, 16'h30CC};
        t3_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        reset        = 1'b1;
        start        = 1'b0;
        active_units = '0;
        result_array = '0;
        ready_array  = '0;
        out_ready    = 1'b0;
        tick();
        tick();
        check_quiet("rst");
        reset = 1'b0;
        tick();

        // ---- Test 1: sparse mask 0x8029, out-of-order ready pulses
        for (int i = 0; i < NU; i++) result_array[i] = 16'(16'hA000 + i * 16'h0101);
        out_ready    = 1'b1;
        start        = 1'b1;
        active_units = 16'h8029;
        tick();                                   // cycle 0
        start        = 1'b0;
        active_units = '0;
        check_val("t1 busy", 32'(busy), 32'd1);
        tick();                                   // cycle 1
        ready_array = 16'h8000;
        tick();                                   // cycle 2
        ready_array = '0;
        tick();                                   // cycle 3
        ready_array = 16'h0023;                   // lane 1 is outside the job
        tick();                                   // cycle 4
        ready_array = '0;
        for (int c = 5; c < 9; c++) tick();
        check_val("t1 pre valid", 32'(out_valid), 32'd0);
        ready_array = 16'h0008;
        tick();                                   // cycle 9
        ready_array = '0;
        for (int b = 0; b < 4; b++) begin
            check_beat("t1 beat", t1_idx[b], t1_dat[b], b == 3);
            tick();
        end
        check_val("t1 post valid", 32'(out_valid), 32'd0);
        check_val("t1 post busy",  32'(busy),      32'd0);
        check_val("t1 done",       32'(done),      32'd1);
        tick();
        check_val("t1 done pulse", 32'(done),      32'd0);

        // ---- Test 2: all lanes, held ready, data changing every cycle
        out_ready    = 1'b0;
        start        = 1'b1;
        active_units = 16'hFFFF;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            for (int i = 0; i < NU; i++) result_array[i] = 16'(c * 16'h1000 + i * 16'h0011);
            if (c == 2) ready_array = 16'hFFFF;
            tick();
        end
        check_beat("t2 stall", 0, 16'h2000, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < NU; i++) begin
            check_beat("t2 beat", i, 16'(16'h2000 + i * 16'h0011), i == NU - 1);
            result_array[i] = 16'hDEAD;
            tick();
        end
        ready_array = '0;
        check_val("t2 done", 32'(done),      32'd1);
        check_val("t2 idle", 32'(out_valid), 32'd0);

        // ---- Test 3: backpressure pattern during a 4-beat drain
        for (int i = 0; i < NU; i++) result_array[i] = 16'(16'h3000 + i * 16'h0011);
        out_ready    = 1'b0;
        start        = 1'b1;
        active_units = 16'h1106;
        tick();
        start       = 1'b0;
        ready_array = 16'h1106;
        tick();
        ready_array = '0;
        pos = 0;
        for (int k = 0; k < 6; k++) begin
            out_ready = t3_rdy[k];
            check_beat("t3 beat", t3_idx[pos], t3_dat[pos], pos == 3);
            tick();
            if (t3_rdy[k]) pos++;
        end
        check_val("t3 accepted", 32'(pos), 32'd3);
        out_ready = 1'b1;
        check_beat("t3 final", t3_idx[3], t3_dat[3], 1'b1);
        tick();
        check_val("t3 done", 32'(done), 32'd1);

        // ---- Test 4: empty job
        start        = 1'b1;
        active_units = '0;
        tick();
        start = 1'b0;
        check_val("t4 done",  32'(done),      32'd1);
        check_val("t4 busy",  32'(busy),      32'd0);
        check_val("t4 valid", 32'(out_valid), 32'd0);
        tick();
        check_val("t4 done pulse", 32'(done),      32'd0);
        check_val("t4 valid2",     32'(out_valid), 32'd0);

        // ---- Test 5: starts while busy are dropped
        for (int i = 0; i < NU; i++) result_array[i] = 16'(16'h5000 + i);
        out_ready    = 1'b0;
        start        = 1'b1;
        active_units = 16'h0011;
        tick();
        active_units = 16'hFFFF;                  // second start during COLLECT
        tick();
        start = 1'b0;
        check_val("t5 drop collect", 32'(start_dropped), 32'd1);
        check_val("t5 busy",         32'(busy),          32'd1);
        tick();
        check_val("t5 drop pulse",   32'(start_dropped), 32'd0);
        ready_array = 16'h0011;
        tick();
        ready_array = '0;
        start       = 1'b1;                       // start during DRAIN
        tick();
        start = 1'b0;
        check_val("t5 drop drain", 32'(start_dropped), 32'd1);
        check_beat("t5 beat0", 0, 16'h5000, 1'b0);
        out_ready = 1'b1;
        tick();
        check_beat("t5 beat1", 4, 16'h5004, 1'b1);
        start        = 1'b1;                      // same cycle as final accepted beat
        active_units = 16'h0003;
        tick();
        start = 1'b0;
        check_val("t5 drop last", 32'(start_dropped), 32'd1);
        check_val("t5 done",      32'(done),          32'd1);
        check_val("t5 idle busy", 32'(busy),          32'd0);
        tick();
        check_val("t5 not started", 32'(busy), 32'd0);

        // ---- Test 6: reset in the middle of a drain, then a fresh job
        start        = 1'b1;
        active_units = 16'h000F;
        tick();
        start       = 1'b0;
        ready_array = 16'h000F;
        tick();
        ready_array = '0;
        out_ready   = 1'b1;
        check_beat("t6 beat0", 0, 16'h5000, 1'b0);
        tick();
        check_beat("t6 beat1", 1, 16'h5001, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        check_quiet("t6 rst");
        reset     = 1'b0;
        out_ready = 1'b0;
        tick();
        check_quiet("t6 after");
        result_array[6] = 16'h6666;
        start           = 1'b1;
        active_units    = 16'h0040;
        tick();
        start       = 1'b0;
        ready_array = 16'h0040;
        check_val("t6 early valid", 32'(out_valid), 32'd0);
        tick();
        ready_array = '0;
        check_beat("t6 fresh", 6, 16'h6666, 1'b1);
        out_ready = 1'b1;
        tick();
        check_val("t6 fresh done", 32'(done), 32'd1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
